// File: rtl/regfile_dump_reader_if.sv
// Bundle between the dump reader, the register-file debug port and the word sink.
// master: the reader itself; slave: the side that supplies control, register data and ready.
interface regfile_dump_reader_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
);
    // control
    logic                     start;
    logic                     abort;
    logic [ADDRESS_WIDTH-1:0] first_addr;
    logic [ADDRESS_WIDTH-1:0] last_addr;

    // register file debug port
    logic [ADDRESS_WIDTH-1:0] testRegAddress;
    logic [DATA_WIDTH-1:0]    testRegData;

    // word stream
    logic [DATA_WIDTH-1:0]    out_data;
    logic [ADDRESS_WIDTH-1:0] out_addr;
    logic                     out_valid;
    logic                     out_ready;

    // status
    logic                     busy;
    logic                     done;
    logic [ADDRESS_WIDTH:0]   count;

    modport master (
        input  start, abort, first_addr, last_addr, testRegData, out_ready,
        output testRegAddress, out_data, out_addr, out_valid, busy, done, count
    );

    modport slave (
        output start, abort, first_addr, last_addr, testRegData, out_ready,
        input  testRegAddress, out_data, out_addr, out_valid, busy, done, count
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Sweeps a register index range on the debug port and streams (addr, data) pairs.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; outputs hold their last values
// FETCH | debug address is settled; capture register word next edge
// SEND  | word presented with out_valid; wait for out_ready
// DONE  | one-cycle done pulse, then back to IDLE
module regfile_dump_reader #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_dump_reader_if.master bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] SEND  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]               r_state;
    logic [ADDRESS_WIDTH-1:0] r_last;
    logic [ADDRESS_WIDTH-1:0] r_reg_addr;
    logic [DATA_WIDTH-1:0]    r_out_data;
    logic [ADDRESS_WIDTH-1:0] r_out_addr;
    logic                     r_out_valid;
    logic [ADDRESS_WIDTH:0]   r_count;

    logic                     w_handshake;
    logic                     w_is_last;
    logic [ADDRESS_WIDTH-1:0] w_next_addr;

    assign w_handshake = r_out_valid && bus.out_ready;
    assign w_is_last   = (r_out_addr == r_last);
    // Natural overflow of the index width gives the modulo wrap (31 -> 0).
    assign w_next_addr = r_out_addr + 1'b1;

    // Sequencer: range latch, word capture, handshake accounting and abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_last      <= '0;
            r_reg_addr  <= '0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_valid <= 1'b0;
            r_count     <= '0;
        end else if (r_state == IDLE) begin
            // start wins over a simultaneous abort, which means nothing here
            if (bus.start) begin
                r_last     <= bus.last_addr;
                r_reg_addr <= bus.first_addr;
                r_count    <= '0;
                r_state    <= FETCH;
            end
        end else if (bus.abort) begin
            // abort beats a same-edge handshake: that word is dropped, not counted
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
        end else begin
            case (r_state)
                FETCH: begin
                    r_out_data  <= bus.testRegData;
                    r_out_addr  <= r_reg_addr;
                    r_out_valid <= 1'b1;
                    r_state     <= SEND;
                end
                SEND: begin
                    if (w_handshake) begin
                        r_count     <= r_count + 1'b1;
                        r_out_valid <= 1'b0;
                        if (w_is_last) begin
                            r_state <= DONE;
                        end else begin
                            r_reg_addr <= w_next_addr;
                            r_state    <= FETCH;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.testRegAddress = r_reg_addr;
    assign bus.out_data       = r_out_data;
    assign bus.out_addr       = r_out_addr;
    assign bus.out_valid      = r_out_valid;
    assign bus.count          = r_count;
    assign bus.busy           = (r_state == FETCH) || (r_state == SEND);
    assign bus.done           = (r_state == DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural register file.
module tb_regfile_dump_reader;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regfile_dump_reader_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) bus ();

    regfile_dump_reader #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] regs [32];
    assign bus.testRegData = regs[bus.testRegAddress];

    int n_pass  = 0;
    int n_total = 0;

    logic [4:0]  got_addr [$];
    logic [31:0] got_data [$];
    logic        busy_log [$];
    int          done_edge;
    bit          stable_ok;
    bit          aborted;

    // x0 reads zero; x1..x31 hold 0x1000_0000 + index
    function automatic logic [31:0] ref_data(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : (32'h1000_0000 + {27'd0, a});
    endfunction

    // Runs one sweep. mode 0: ready always 1; mode 1: ready 0,0,1 per word;
    // mode 2: ready 1 plus a stray start pulse while busy.
    // abort_at > 0 asserts abort on the same edge as that handshake number.
    task automatic sweep_collect(input logic [4:0] first, input logic [4:0] last,
                                 input int mode, input int abort_at);
        int          edge_n;
        int          vcyc;
        bit          in_word;
        logic [4:0]  hold_a;
        logic [31:0] hold_d;
        got_addr.delete();
        got_data.delete();
        busy_log.delete();
        done_edge = -1;
        stable_ok = 1'b1;
        aborted   = 1'b0;
        in_word   = 1'b0;
        vcyc      = 0;
        hold_a    = '0;
        hold_d    = '0;
        @(negedge clk);
        bus.first_addr = first;
        bus.last_addr  = last;
        bus.start      = 1'b1;
        bus.out_ready  = (mode != 1);
        @(posedge clk);
        edge_n = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.abort = 1'b0;
            busy_log.push_back(bus.busy);
            if (bus.done) begin
                done_edge = edge_n;
                break;
            end
            if (mode == 2 && edge_n == 3) begin
                bus.start      = 1'b1;
                bus.first_addr = 5'd20;
                bus.last_addr  = 5'd20;
            end
            if (bus.out_valid) begin
                if (!in_word) begin
                    hold_a  = bus.out_addr;
                    hold_d  = bus.out_data;
                    in_word = 1'b1;
                    vcyc    = 0;
                end else if (bus.out_addr !== hold_a || bus.out_data !== hold_d) begin
                    stable_ok = 1'b0;
                end
                bus.out_ready = (mode == 1) ? (vcyc == 2) : 1'b1;
                vcyc++;
                if (bus.out_ready) begin
                    if (abort_at > 0 && got_addr.size() == abort_at - 1) begin
                        bus.abort = 1'b1;
                    end else begin
                        got_addr.push_back(bus.out_addr);
                        got_data.push_back(bus.out_data);
                    end
                    in_word = 1'b0;
                end
            end else begin
                bus.out_ready = (mode != 1);
            end
            @(posedge clk);
            edge_n++;
            if (bus.abort) begin
                aborted = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_total++;
        if (bus.testRegAddress !== 5'd0 || bus.out_data !== 32'd0 || bus.out_addr !== 5'd0 ||
            bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.count !== 6'd0)
            $display("FAIL reset_outputs: got addr=%0d data=%h oaddr=%0d valid=%b busy=%b done=%b count=%0d, expected all zero",
                     bus.testRegAddress, bus.out_data, bus.out_addr, bus.out_valid, bus.busy, bus.done, bus.count);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_range();
        logic [4:0] exp_a;
        sweep_collect(5'd0, 5'd31, 0, 0);
        n_total++;
        if (got_addr.size() != 32) $display("FAIL full_word_count: got %0d expected 32", got_addr.size());
        else n_pass++;
        for (int k = 0; k < 32 && k < got_addr.size(); k++) begin
            exp_a = 5'(k);
            n_total++;
            if (got_addr[k] !== exp_a || got_data[k] !== ref_data(exp_a))
                $display("FAIL full_word[%0d]: got (%0d,%h) expected (%0d,%h)",
                         k, got_addr[k], got_data[k], exp_a, ref_data(exp_a));
            else n_pass++;
        end
        n_total++;
        if (got_data.size() > 0 && got_data[0] !== 32'h0)
            $display("FAIL full_x0_zero: got %h expected 00000000", got_data[0]);
        else n_pass++;
        n_total++;
        if (done_edge != 64) $display("FAIL full_done_edge: got %0d expected 64", done_edge);
        else n_pass++;
        n_total++;
        if (bus.count !== 6'd32) $display("FAIL full_count: got %0d expected 32", bus.count);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.count !== 6'd32)
            $display("FAIL full_after_done: got done=%b busy=%b count=%0d expected 0,0,32",
                     bus.done, bus.busy, bus.count);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [4:0] exp_a;
        sweep_collect(5'd30, 5'd1, 0, 0);
        n_total++;
        if (got_addr.size() != 4) $display("FAIL wrap_word_count: got %0d expected 4", got_addr.size());
        else n_pass++;
        for (int k = 0; k < 4 && k < got_addr.size(); k++) begin
            exp_a = 5'd30 + 5'(k);
            n_total++;
            if (got_addr[k] !== exp_a || got_data[k] !== ref_data(exp_a))
                $display("FAIL wrap_word[%0d]: got (%0d,%h) expected (%0d,%h)",
                         k, got_addr[k], got_data[k], exp_a, ref_data(exp_a));
            else n_pass++;
        end
        n_total++;
        if (bus.count !== 6'd4 || done_edge != 8)
            $display("FAIL wrap_count_done: got count=%0d done_edge=%0d expected 4,8", bus.count, done_edge);
        else n_pass++;
    endtask

    task automatic test_single();
        sweep_collect(5'd5, 5'd5, 0, 0);
        n_total++;
        if (got_addr.size() != 1 || got_addr[0] !== 5'd5 || got_data[0] !== 32'h1000_0005)
            $display("FAIL single_word: got %0d words first=(%0d,%h) expected 1 word (5,10000005)",
                     got_addr.size(), (got_addr.size() > 0) ? got_addr[0] : 5'd0,
                     (got_data.size() > 0) ? got_data[0] : 32'd0);
        else n_pass++;
        n_total++;
        if (done_edge != 2) $display("FAIL single_done_edge: got %0d expected 2", done_edge);
        else n_pass++;
        n_total++;
        if (busy_log.size() != 3 || busy_log[0] !== 1'b1 || busy_log[1] !== 1'b1 || busy_log[2] !== 1'b0)
            $display("FAIL single_busy: got %0d samples b0=%b b1=%b b2=%b expected 3 samples 1,1,0",
                     busy_log.size(), (busy_log.size() > 0) ? busy_log[0] : 1'bx,
                     (busy_log.size() > 1) ? busy_log[1] : 1'bx, (busy_log.size() > 2) ? busy_log[2] : 1'bx);
        else n_pass++;
        n_total++;
        if (bus.count !== 6'd1) $display("FAIL single_count: got %0d expected 1", bus.count);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [4:0] exp_a;
        sweep_collect(5'd0, 5'd3, 1, 0);
        n_total++;
        if (got_addr.size() != 4) $display("FAIL bp_word_count: got %0d expected 4", got_addr.size());
        else n_pass++;
        for (int k = 0; k < 4 && k < got_addr.size(); k++) begin
            exp_a = 5'(k);
            n_total++;
            if (got_addr[k] !== exp_a || got_data[k] !== ref_data(exp_a))
                $display("FAIL bp_word[%0d]: got (%0d,%h) expected (%0d,%h)",
                         k, got_addr[k], got_data[k], exp_a, ref_data(exp_a));
            else n_pass++;
        end
        n_total++;
        if (stable_ok !== 1'b1) $display("FAIL bp_stable: got %b expected 1", stable_ok);
        else n_pass++;
        n_total++;
        if (done_edge != 16 || bus.count !== 6'd4)
            $display("FAIL bp_done_count: got done_edge=%0d count=%0d expected 16,4", done_edge, bus.count);
        else n_pass++;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_abort();
        sweep_collect(5'd0, 5'd7, 0, 3);
        n_total++;
        if (aborted !== 1'b1 || got_addr.size() != 2)
            $display("FAIL abort_reached: got aborted=%b words=%0d expected 1,2", aborted, got_addr.size());
        else n_pass++;
        @(negedge clk);
        bus.abort = 1'b0;
        n_total++;
        if (bus.done !== 1'b0 || bus.count !== 6'd2 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL abort_state: got done=%b count=%0d valid=%b busy=%b expected 0,2,0,0",
                     bus.done, bus.count, bus.out_valid, bus.busy);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL abort_no_done: got done=%b busy=%b expected 0,0", bus.done, bus.busy);
        else n_pass++;
        sweep_collect(5'd7, 5'd8, 0, 0);
        n_total++;
        if (got_addr.size() != 2 || got_addr[0] !== 5'd7 || got_data[1] !== 32'h1000_0008 ||
            done_edge != 4 || bus.count !== 6'd2)
            $display("FAIL abort_restart: got words=%0d done_edge=%0d count=%0d expected 2,4,2",
                     got_addr.size(), done_edge, bus.count);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.first_addr = 5'd9;
        bus.last_addr  = 5'd12;
        bus.out_ready  = 1'b0;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        n_total++;
        if (bus.out_valid !== 1'b1 || bus.out_addr !== 5'd9 || bus.out_data !== 32'h1000_0009)
            $display("FAIL rst_precond: got valid=%b addr=%0d data=%h expected 1,9,10000009",
                     bus.out_valid, bus.out_addr, bus.out_data);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_total++;
        if (bus.testRegAddress !== 5'd0 || bus.out_data !== 32'd0 || bus.out_addr !== 5'd0 ||
            bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.count !== 6'd0)
            $display("FAIL rst_async: got addr=%0d data=%h oaddr=%0d valid=%b busy=%b done=%b count=%0d, expected all zero",
                     bus.testRegAddress, bus.out_data, bus.out_addr, bus.out_valid, bus.busy, bus.done, bus.count);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0)
            $display("FAIL rst_stays_idle: got busy=%b valid=%b expected 0,0", bus.busy, bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_start_while_busy();
        logic [4:0] exp_a;
        sweep_collect(5'd10, 5'd12, 2, 0);
        n_total++;
        if (got_addr.size() != 3) $display("FAIL busy_start_count: got %0d words expected 3", got_addr.size());
        else n_pass++;
        for (int k = 0; k < 3 && k < got_addr.size(); k++) begin
            exp_a = 5'd10 + 5'(k);
            n_total++;
            if (got_addr[k] !== exp_a || got_data[k] !== ref_data(exp_a))
                $display("FAIL busy_start_word[%0d]: got (%0d,%h) expected (%0d,%h)",
                         k, got_addr[k], got_data[k], exp_a, ref_data(exp_a));
            else n_pass++;
        end
        n_total++;
        if (done_edge != 6 || bus.count !== 6'd3)
            $display("FAIL busy_start_done: got done_edge=%0d count=%0d expected 6,3", done_edge, bus.count);
        else n_pass++;
    endtask

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.first_addr = '0;
        bus.last_addr  = '0;
        bus.out_ready  = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = ref_data(5'(i));

        test_reset();
        test_full_range();
        test_wrap();
        test_single();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_start_while_busy();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
